// File: rtl/p2s_pkg.sv
// Shared types and defaults for the parallel-to-serial transmit slice.
package p2s_pkg;

    typedef enum logic {
        SYNC   = 1'b0,
        ACTIVE = 1'b1
    } p2s_state_t;

    localparam int              P2S_WIDTH      = 8;
    localparam logic [7:0]      P2S_IDLE_SYM   = 8'hBC;
    localparam int              P2S_SYNC_WORDS = 4;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tx_fifo2.sv
// Two-entry first-word-fall-through buffer between the mux and the serialiser.
module tx_fifo2
    import p2s_pkg::*;
#(
    parameter int WIDTH = P2S_WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic [1:0]       count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem_reg [2];
    logic             wr_ptr_reg;
    logic             rd_ptr_reg;
    logic [1:0]       count_reg;
    logic             do_push;
    logic             do_pop;

    always_comb begin
        full    = (count_reg == 2'd2);
        empty   = (count_reg == 2'd0);
        do_push = push & ~full;
        do_pop  = pop & ~empty;
        head    = mem_reg[rd_ptr_reg];
        count   = count_reg;
    end

    // Storage is not reset; only the pointers and occupancy decide what is valid.
    for (genvar gi = 0; gi < 2; gi++) begin : g_entry
        always_ff @(posedge clk) begin
            if (do_push && (wr_ptr_reg == 1'(gi))) begin
                mem_reg[gi] <= data_in;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            count_reg  <= 2'd0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (do_pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            count_reg <= count_reg + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

endmodule

// File: rtl/par_to_serial_tx.sv
// Serialises buffered mux words MSB first, filling idle frames with the comma
// symbol and forcing a comma burst after every reset for receiver alignment.
module par_to_serial_tx
    import p2s_pkg::*;
#(
    parameter int               WIDTH      = P2S_WIDTH,
    parameter logic [WIDTH-1:0] IDLE_SYM   = WIDTH'(P2S_IDLE_SYM),
    parameter int               SYNC_WORDS = P2S_SYNC_WORDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             valid_in,
    output logic             ready_out,
    output logic             data_out,
    output logic             word_start,
    output logic             sync_done
);

    localparam int BCW = cnt_width(WIDTH);
    localparam int SCW = cnt_width(SYNC_WORDS + 1);

    logic [BCW-1:0]   bit_cnt_reg;
    logic [SCW-1:0]   sync_cnt_reg;
    p2s_state_t       state_reg;
    logic [WIDTH-1:0] shreg_reg;
    logic             data_out_reg;
    logic             word_start_reg;
    logic             sync_done_reg;
    logic             ready_reg;

    logic             load;
    logic             sync_exit;
    logic             send_data;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] next_word;
    logic [1:0]       count_next;

    logic [WIDTH-1:0] fifo_head;
    logic [1:0]       fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    tx_fifo2 #(
        .WIDTH (WIDTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .data_in (data_in),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The exit load already behaves as ACTIVE: it may carry buffered data.
    always_comb begin
        load       = (bit_cnt_reg == '0);
        sync_exit  = (state_reg == SYNC) && (sync_cnt_reg == SCW'(SYNC_WORDS));
        send_data  = (state_reg == ACTIVE) || sync_exit;
        push       = valid_in & ready_reg & ~fifo_full;
        pop        = load & send_data & ~fifo_empty;
        next_word  = pop ? fifo_head : IDLE_SYM;
        count_next = fifo_count + {1'b0, push} - {1'b0, pop};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt_reg    <= '0;
            sync_cnt_reg   <= '0;
            state_reg      <= SYNC;
            shreg_reg      <= '0;
            data_out_reg   <= 1'b0;
            word_start_reg <= 1'b0;
            sync_done_reg  <= 1'b0;
            ready_reg      <= 1'b0;
        end else begin
            bit_cnt_reg <= (bit_cnt_reg == BCW'(WIDTH - 1)) ? '0 : bit_cnt_reg + 1'b1;
            ready_reg   <= (count_next < 2'd2);
            if (load) begin
                data_out_reg   <= next_word[WIDTH-1];
                shreg_reg      <= next_word << 1;
                word_start_reg <= 1'b1;
                if (sync_exit) begin
                    state_reg     <= ACTIVE;
                    sync_done_reg <= 1'b1;
                end else if (state_reg == SYNC) begin
                    sync_cnt_reg <= sync_cnt_reg + 1'b1;
                end
            end else begin
                data_out_reg   <= shreg_reg[WIDTH-1];
                shreg_reg      <= shreg_reg << 1;
                word_start_reg <= 1'b0;
            end
        end
    end

    assign data_out   = data_out_reg;
    assign word_start = word_start_reg;
    assign sync_done  = sync_done_reg;
    assign ready_out  = ready_reg;

endmodule

// File: tb/tb_par_to_serial_tx.sv
// Directed plus random stimulus for par_to_serial_tx against a frame-level reference model.
module tb_par_to_serial_tx;

    localparam logic [7:0] COMMA = 8'hBC;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h00;
    logic       valid_in = 1'b0;
    logic       ready_out;
    logic       data_out;
    logic       word_start;
    logic       sync_done;

    int checks = 0;
    int failures = 0;

    // Reference model state: edge index since reset, frame word, buffered words.
    int         e = 0;
    logic [7:0] cur_word = COMMA;
    logic [7:0] q[$];
    logic       exp_do = 1'b0;
    logic       exp_ws = 1'b0;
    logic       exp_sd = 1'b0;
    logic       exp_rdy = 1'b0;
    logic       accepted = 1'b0;
    logic [7:0] rx = 8'h00;

    par_to_serial_tx dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .valid_in   (valid_in),
        .ready_out  (ready_out),
        .data_out   (data_out),
        .word_start (word_start),
        .sync_done  (sync_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h at edge %0d", tag, obs, expv, e);
        end
    endtask

    // Frame k (8 edges each) carries a comma for k<4, otherwise the oldest
    // buffered word present before its first edge, or a comma if none.
    task automatic model_edge();
        int bit_i;
        accepted = 1'b0;
        if (reset) begin
            q.delete();
            e = 0;
            exp_do = 1'b0;
            exp_ws = 1'b0;
            exp_sd = 1'b0;
            exp_rdy = 1'b0;
            return;
        end
        bit_i = e % 8;
        if (bit_i == 0) begin
            if ((e / 8) < 4 || q.size() == 0) cur_word = COMMA;
            else cur_word = q.pop_front();
        end
        if (valid_in && exp_rdy) begin
            q.push_back(data_in);
            accepted = 1'b1;
        end
        exp_do = cur_word[7 - bit_i];
        exp_ws = (bit_i == 0);
        exp_sd = (e >= 32);
        exp_rdy = (q.size() < 2);
        e++;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("data_out", {7'd0, data_out}, {7'd0, exp_do});
        chk("word_start", {7'd0, word_start}, {7'd0, exp_ws});
        chk("sync_done", {7'd0, sync_done}, {7'd0, exp_sd});
        chk("ready_out", {7'd0, ready_out}, {7'd0, exp_rdy});
        rx = {rx[6:0], data_out};
        if (!reset && ((e - 1) % 8 == 7)) begin
            chk("frame", rx, cur_word);
            if (cur_word != COMMA) $display("frame  word=%02h rx=%02h", cur_word, rx);
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic push_word(input logic [7:0] w);
        logic done;
        done = 1'b0;
        data_in = w;
        valid_in = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            tick();
            done = accepted;
        end
        valid_in = 1'b0;
        checks++;
        if (!done) begin
            failures++;
            $error("FAIL push_timeout observed=0 expected=1 word=%02h", w);
        end else begin
            $display("push   word=%02h at edge %0d", w, e - 1);
        end
    endtask

    task automatic do_reset(input int n);
        valid_in = 1'b0;
        reset = 1'b1;
        ticks(n);
        reset = 1'b0;
    endtask

    initial begin
        logic found;

        // 1: reset then comma stream, sync_done after the fourth comma frame
        do_reset(3);
        ticks(45);

        // 2: single data word after sync
        push_word(8'hA5);
        ticks(20);

        // 3: back-to-back pushes, third waits for the first pop
        push_word(8'h01);
        push_word(8'h02);
        push_word(8'h03);
        ticks(30);

        // 4: push during SYNC is held until the first post-sync frame
        do_reset(1);
        ticks(5);
        push_word(8'h3C);
        ticks(50);

        // 5: reset in the middle of a data word with one word still buffered
        push_word(8'hFF);
        push_word(8'h77);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            tick();
            found = (cur_word == 8'hFF) && ((e - 1) % 8 == 3);
        end
        checks++;
        if (!found) begin
            failures++;
            $error("FAIL mid_word_wait observed=0 expected=1");
        end
        do_reset(1);
        ticks(40);

        // 6: push exactly on a load edge into an empty buffer
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((e % 8 == 0) && (q.size() == 0) && (e >= 40)) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            failures++;
            $error("FAIL load_edge_wait observed=0 expected=1");
        end
        data_in = 8'h5A;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("load_push_accepted", {7'd0, accepted}, 8'd1);
        chk("load_push_frame_is_comma", cur_word, COMMA);
        ticks(20);

        // Random traffic with held valid and one mid-stream reset
        for (int c = 0; c < 600; c++) begin
            if (c == 300) begin
                do_reset(2);
            end
            if (!valid_in && ($urandom % 6 == 0)) begin
                data_in = 8'($urandom);
                valid_in = 1'b1;
            end
            tick();
            if (accepted) begin
                $display("push   word=%02h at edge %0d", data_in, e - 1);
                valid_in = 1'b0;
            end
        end
        valid_in = 1'b0;
        ticks(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
